// File: rtl/ex_muldiv_if.sv
// Bundle of the ID/EX-facing request signals and the EX/ctrl-facing
// response signals of the iterative multiply/divide unit.
interface ex_muldiv_if #(
    parameter int DW = 32
);
    logic          start_i;
    logic [2:0]    funct3_i;
    logic [DW-1:0] op1_i;
    logic [DW-1:0] op2_i;
    logic [4:0]    rd_addr_i;
    logic          flush_i;

    logic [DW-1:0] result_o;
    logic [4:0]    rd_addr_o;
    logic          regs_wen_o;
    logic          done_o;
    logic          busy_o;
    logic          hold_req_o;

    // Pipeline side: drives the request, observes the result.
    modport master (
        output start_i, funct3_i, op1_i, op2_i, rd_addr_i, flush_i,
        input  result_o, rd_addr_o, regs_wen_o, done_o, busy_o, hold_req_o
    );

    // Unit side.
    modport slave (
        input  start_i, funct3_i, op1_i, op2_i, rd_addr_i, flush_i,
        output result_o, rd_addr_o, regs_wen_o, done_o, busy_o, hold_req_o
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit. Multiplies by 32-step shift-add on
// operand magnitudes, divides by 32-step restoring division, and applies
// the sign correction once when the result is committed to result_o.
module ex_muldiv #(
    parameter int DW = 32
) (
    input  logic           clk,
    input  logic           rstn,   // synchronous, active-high despite the name
    ex_muldiv_if.slave     bus
);
    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;

    localparam logic [DW-1:0] MIN_NEG  = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] ALL_ONES = {DW{1'b1}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_reg,  state_next;
    logic [4:0]      cnt_reg,    cnt_next;
    logic [2:0]      funct3_reg, funct3_next;
    logic [4:0]      rd_reg,     rd_next;
    logic            neg1_reg,   neg1_next;   // rs1 treated as negative
    logic            neg2_reg,   neg2_next;   // rs2 treated as negative
    logic [DW-1:0]   mcand_reg,  mcand_next;  // multiplicand or divisor magnitude
    logic [2*DW-1:0] acc_reg,    acc_next;    // {hi, multiplier} or {rem, quot}
    logic [DW-1:0]   result_reg, result_next;
    logic            hold_req;

    // Decode of the incoming instruction: signedness, magnitudes, special cases.
    logic          is_div_in, sign1_in, sign2_in, div_zero, div_ovf;
    logic [DW-1:0] mag1_in, mag2_in, special_res;

    always_comb begin
        is_div_in = bus.funct3_i[2];
        sign1_in  = ((bus.funct3_i == F_MULH) || (bus.funct3_i == F_MULHSU) ||
                     (bus.funct3_i == F_DIV)  || (bus.funct3_i == F_REM)) && bus.op1_i[DW-1];
        sign2_in  = ((bus.funct3_i == F_MULH) || (bus.funct3_i == F_DIV) ||
                     (bus.funct3_i == F_REM)) && bus.op2_i[DW-1];
        mag1_in   = sign1_in ? (~bus.op1_i + 1'b1) : bus.op1_i;
        mag2_in   = sign2_in ? (~bus.op2_i + 1'b1) : bus.op2_i;
        div_zero  = is_div_in && (bus.op2_i == '0);
        div_ovf   = ((bus.funct3_i == F_DIV) || (bus.funct3_i == F_REM)) &&
                    (bus.op1_i == MIN_NEG) && (bus.op2_i == ALL_ONES);
        // Divide-by-zero: quotient all ones, remainder = dividend.
        // Signed overflow: quotient = most negative value, remainder 0.
        special_res = '0;
        if (div_zero)
            special_res = bus.funct3_i[1] ? bus.op1_i : ALL_ONES;
        else if (div_ovf)
            special_res = bus.funct3_i[1] ? '0 : MIN_NEG;
    end

    // One iteration of the datapath plus the sign-fixed result it would yield.
    logic [DW:0]     mul_sum, div_trial;
    logic [2*DW-1:0] mul_step, div_step, step, prod_fix;
    logic [DW-1:0]   quot_fix, rem_fix, final_res;

    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*DW-1:DW]} + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
        mul_step  = {mul_sum, acc_reg[DW-1:1]};
        // The shifted partial remainder needs DW+1 bits before the compare.
        div_trial = acc_reg[2*DW-1:DW-1] - {1'b0, mcand_reg};
        if (!div_trial[DW])
            div_step = {div_trial[DW-1:0], acc_reg[DW-2:0], 1'b1};
        else
            div_step = {acc_reg[2*DW-2:0], 1'b0};
        step      = funct3_reg[2] ? div_step : mul_step;

        prod_fix  = (neg1_reg ^ neg2_reg) ? (~step + 1'b1) : step;
        quot_fix  = (neg1_reg ^ neg2_reg) ? (~step[DW-1:0] + 1'b1) : step[DW-1:0];
        rem_fix   = neg1_reg ? (~step[2*DW-1:DW] + 1'b1) : step[2*DW-1:DW];

        case (funct3_reg)
            F_MUL:                      final_res = prod_fix[DW-1:0];
            F_MULH, F_MULHSU, F_MULHU:  final_res = prod_fix[2*DW-1:DW];
            F_DIV, F_DIVU:              final_res = quot_fix;
            default:                    final_res = rem_fix;
        endcase
    end

    // Next-state logic and hold request; flush overrides everything.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        funct3_next = funct3_reg;
        rd_next     = rd_reg;
        neg1_next   = neg1_reg;
        neg2_next   = neg2_reg;
        mcand_next  = mcand_reg;
        acc_next    = acc_reg;
        result_next = result_reg;
        hold_req    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.start_i && !bus.flush_i) begin
                    hold_req    = 1'b1;
                    funct3_next = bus.funct3_i;
                    rd_next     = bus.rd_addr_i;
                    neg1_next   = sign1_in;
                    neg2_next   = sign2_in;
                    cnt_next    = '0;
                    mcand_next  = is_div_in ? mag2_in : mag1_in;
                    acc_next    = {{DW{1'b0}}, (is_div_in ? mag1_in : mag2_in)};
                    if (div_zero || div_ovf) begin
                        result_next = special_res;
                        state_next  = DONE;
                    end else begin
                        state_next  = CALC;
                    end
                end
            end
            CALC: begin
                hold_req = 1'b1;
                acc_next = step;
                cnt_next = cnt_reg + 5'd1;
                if (cnt_reg == 5'd31) begin
                    result_next = final_res;
                    state_next  = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (bus.flush_i) begin
            state_next  = IDLE;
            result_next = result_reg;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            funct3_reg <= '0;
            rd_reg     <= '0;
            neg1_reg   <= 1'b0;
            neg2_reg   <= 1'b0;
            mcand_reg  <= '0;
            acc_reg    <= '0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            funct3_reg <= funct3_next;
            rd_reg     <= rd_next;
            neg1_reg   <= neg1_next;
            neg2_reg   <= neg2_next;
            mcand_reg  <= mcand_next;
            acc_reg    <= acc_next;
            result_reg <= result_next;
        end
    end

    assign bus.result_o   = result_reg;
    assign bus.rd_addr_o  = rd_reg;
    assign bus.done_o     = (state_reg == DONE);
    assign bus.regs_wen_o = (state_reg == DONE);
    assign bus.busy_o     = (state_reg != IDLE);
    assign bus.hold_req_o = hold_req;
endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: a table of operations with expected
// results and latencies, a scoreboard queue, and hand-written flush and
// reset-abort sequences.
module tb_ex_muldiv;
    logic clk;
    logic rstn;

    ex_muldiv_if #(.DW(32)) bus ();

    ex_muldiv #(.DW(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
        int          lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[20];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one operation, keep it on the inputs until done_o, then compare.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] er, input int el);
        exp_t e;
        int   lat;
        bit   hold_ok;
        e.res = er; e.rd = rd; e.lat = el;
        sb.push_back(e);
        bus.start_i   = 1'b1;
        bus.funct3_i  = f3;
        bus.op1_i     = a;
        bus.op2_i     = b;
        bus.rd_addr_i = rd;
        #1;
        chk({name, " hold_accept"}, {31'b0, bus.hold_req_o}, 32'd1);
        lat = 0;
        hold_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done_o) begin
                lat = k;
                break;
            end
            if (!bus.hold_req_o) hold_ok = 1'b0;
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=no_done expected=done_within_40", name);
            void'(sb.pop_front());
            bus.start_i = 1'b0;
            @(negedge clk);
            return;
        end
        e = sb.pop_front();
        chk({name, " latency"},   lat, e.lat);
        chk({name, " result"},    bus.result_o, e.res);
        chk({name, " rd"},        {27'b0, bus.rd_addr_o}, {27'b0, e.rd});
        chk({name, " wen"},       {31'b0, bus.regs_wen_o}, 32'd1);
        chk({name, " hold_done"}, {31'b0, bus.hold_req_o}, 32'd0);
        chk({name, " hold_calc"}, {31'b0, hold_ok}, 32'd1);
        $display("op %-8s a=%h b=%h rd=%0d -> result=%h latency=%0d",
                 name, a, b, rd, bus.result_o, lat);
        bus.start_i = 1'b0;
        @(negedge clk);
        chk({name, " done_pulse"}, {31'b0, bus.done_o}, 32'd0);
        chk({name, " busy_after"}, {31'b0, bus.busy_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_done;

        vecs[0]  = '{"MUL",     3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33};
        vecs[1]  = '{"MULH",    3'b001, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000, 33};
        vecs[2]  = '{"MULHU",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 33};
        vecs[3]  = '{"MULHSU",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 33};
        vecs[4]  = '{"DIV",     3'b100, 32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD, 33};
        vecs[5]  = '{"REM",     3'b110, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 33};
        vecs[6]  = '{"DIVU",    3'b101, 32'd100,      32'd7,        5'd7,  32'd14,       33};
        vecs[7]  = '{"REMU",    3'b111, 32'd100,      32'd7,        5'd8,  32'd2,        33};
        vecs[8]  = '{"DIV0",    3'b100, 32'd5,        32'd0,        5'd9,  32'hFFFFFFFF, 1};
        vecs[9]  = '{"REMU0",   3'b111, 32'd5,        32'd0,        5'd10, 32'd5,        1};
        vecs[10] = '{"DIVOVF",  3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1};
        vecs[11] = '{"REMOVF",  3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,        1};
        vecs[12] = '{"DIVU0",   3'b101, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1};
        vecs[13] = '{"REM0",    3'b110, 32'hFFFFFFF9, 32'd0,        5'd14, 32'hFFFFFFF9, 1};
        vecs[14] = '{"MULHmax", 3'b001, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd15, 32'h3FFFFFFF, 33};
        vecs[15] = '{"MULHneg", 3'b001, 32'hFFFFFFFF, 32'd5,        5'd16, 32'hFFFFFFFF, 33};
        vecs[16] = '{"DIVneg",  3'b100, 32'd7,        32'hFFFFFFFE, 5'd17, 32'hFFFFFFFD, 33};
        vecs[17] = '{"REMneg",  3'b110, 32'd7,        32'hFFFFFFFE, 5'd18, 32'd1,        33};
        vecs[18] = '{"DIVUbig", 3'b101, 32'hFFFFFFFF, 32'd1,        5'd19, 32'hFFFFFFFF, 33};
        vecs[19] = '{"MULlow",  3'b000, 32'h12345678, 32'h00010000, 5'd31, 32'h56780000, 33};

        rstn          = 1'b1;
        bus.start_i   = 1'b0;
        bus.funct3_i  = 3'b000;
        bus.op1_i     = '0;
        bus.op2_i     = '0;
        bus.rd_addr_i = '0;
        bus.flush_i   = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);

        chk("reset result",   bus.result_o, 32'd0);
        chk("reset rd",       {27'b0, bus.rd_addr_o}, 32'd0);
        chk("reset wen",      {31'b0, bus.regs_wen_o}, 32'd0);
        chk("reset done",     {31'b0, bus.done_o}, 32'd0);
        chk("reset busy",     {31'b0, bus.busy_o}, 32'd0);
        chk("reset hold",     {31'b0, bus.hold_req_o}, 32'd0);

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd,
                   vecs[i].res, vecs[i].lat);

        // Flush a DIVU in its tenth cycle after accept; no completion may follow.
        bus.start_i   = 1'b1;
        bus.funct3_i  = 3'b101;
        bus.op1_i     = 32'd1000;
        bus.op2_i     = 32'd3;
        bus.rd_addr_i = 5'd20;
        seen_done     = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done_o) seen_done = 1'b1;
        end
        bus.flush_i = 1'b1;
        bus.start_i = 1'b0;
        @(negedge clk);
        bus.flush_i = 1'b0;
        if (bus.done_o || bus.regs_wen_o) seen_done = 1'b1;
        chk("flush busy",    {31'b0, bus.busy_o}, 32'd0);
        chk("flush no_done", {31'b0, seen_done}, 32'd0);
        chk("flush result",  bus.result_o, 32'h56780000);
        $display("op FLUSH    DIVU aborted, busy=%0d", bus.busy_o);
        @(negedge clk);
        run_op("MULflush", 3'b000, 32'd3, 32'd4, 5'd21, 32'd12, 33);

        // Reset in the fifth cycle after accept discards the operation.
        bus.start_i   = 1'b1;
        bus.funct3_i  = 3'b000;
        bus.op1_i     = 32'd9;
        bus.op2_i     = 32'd9;
        bus.rd_addr_i = 5'd22;
        repeat (5) @(negedge clk);
        rstn        = 1'b1;
        bus.start_i = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        chk("rst_mid result", bus.result_o, 32'd0);
        chk("rst_mid rd",     {27'b0, bus.rd_addr_o}, 32'd0);
        chk("rst_mid wen",    {31'b0, bus.regs_wen_o}, 32'd0);
        chk("rst_mid done",   {31'b0, bus.done_o}, 32'd0);
        chk("rst_mid busy",   {31'b0, bus.busy_o}, 32'd0);
        chk("rst_mid hold",   {31'b0, bus.hold_req_o}, 32'd0);
        $display("op RESET    mid-CALC abort, busy=%0d", bus.busy_o);
        @(negedge clk);
        run_op("MULHUrst", 3'b011, 32'd2, 32'd3, 5'd23, 32'd0, 33);

        chk("scoreboard empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit inside the EX stage, fed directly by the ID/EX pipeline register. It accepts one M-extension operation at a time and computes it with a 32-step shift-add (multiply) or restoring (divide) datapath. While the operation is in flight it requests a pipeline hold from ctrl, then returns the result and write-enable to EX for writeback.

## Interface
- `DW`, default 32: operand/result width; only 32 is supported.
- `clk` in 1: clock; all state updates on the rising edge.
- `rstn` in 1: reset. Synchronous and active-high (asserted = 1), despite the name.
- `start_i` in 1: an M-extension instruction is present in EX this cycle. EX decodes opcode 0110011 with funct7 0000001.
- `funct3_i` in 3: operation select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op1_i` in 32: rs1 value (multiplicand/dividend).
- `op2_i` in 32: rs2 value (multiplier/divisor).
- `rd_addr_i` in 5: destination register.
- `flush_i` in 1: from ctrl; aborts any operation.
- `result_o` out 32: result register; holds its last value until the next DONE.
- `rd_addr_o` out 5: latched rd.
- `regs_wen_o` out 1: write-enable; high only in DONE.
- `done_o` out 1: one-cycle completion pulse (DONE state).
- `busy_o` out 1: high in CALC or DONE.
- `hold_req_o` out 1: to ctrl; combinational, equal to (IDLE & start_i & !flush_i) | CALC.

## Operation
- **FSM states:** IDLE, CALC, DONE.
- **IDLE:**
  - When start_i & !flush_i, latch funct3, rd_addr, the operand magnitudes, and the sign flags.
  - Signed operands are rs1 for MULH/MULHSU/DIV/REM, and rs2 for MULH/DIV/REM.
  - Special divide cases go straight to DONE with the result preloaded:
    - divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
    - DIV/REM with 0x80000000 / 0xFFFFFFFF: DIV gives 0x80000000, REM gives 0.
  - All other operations go to CALC with the 5-bit counter cleared.
- **CALC, multiply:**
  - Each cycle, add the multiplicand to the upper half of the 64-bit accumulator if the multiplier LSB is 1.
  - Then shift right one bit.
- **CALC, divide:**
  - Each cycle, shift {rem,quot} left one bit.
  - If rem ≥ divisor, subtract the divisor and set the quotient LSB.
- **CALC exit:** counter == 31 → DONE.
- **Sign fix on entry to DONE:**
  - Product: negate the 64-bit value if the sign flags differ.
  - Quotient: negate if the dividend and divisor signs differ.
  - Remainder: takes the dividend's sign.
  - Select the result: MUL takes the low 32 bits; MULH/MULHSU/MULHU take the high 32 bits.
- **DONE:** assert done_o and regs_wen_o, then → IDLE.
  - start_i is ignored in CALC and DONE. The held instruction stays on the inputs and must not restart.
- **flush_i:** in any state, forces IDLE on the next edge with no done_o/regs_wen_o pulse. It has priority over start_i.
- **Reset:** state IDLE, counter 0, result_o 0, rd_addr_o 0, regs_wen_o/done_o/busy_o 0.
  - Reset mid-CALC discards the operation.

## Timing
- start_i accepted at edge T (IDLE) → CALC during cycles T+1..T+32 → DONE in cycle T+33.
  - 33-cycle latency from the accept cycle; 32 CALC cycles.
- Special divide cases: DONE in cycle T+1 (latency 1).
- hold_req_o covers:
  - normal operations: the accept cycle through the last CALC cycle;
  - special cases: the accept cycle only.
- hold_req_o is low in DONE, so ctrl releases ID/EX and the result commits that same cycle.
- Back-to-back M instructions: the second is accepted in the cycle after DONE. Throughput is 1 op per 34 cycles.

## Test plan
- **Signed MUL:** MUL 7 × 0xFFFFFFFD, rd=5, start at T → result_o 0xFFFFFFEB, regs_wen_o=1, rd_addr_o=5, done_o high only in cycle T+33; hold_req_o low in T+33.
- **High-half multiplies:**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- **Divide/remainder:**
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14; REMU → 2.
- **Special cases (each with done_o at T+1):**
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- **Flush:** flush_i in cycle T+10 of a DIVU → IDLE at T+11; no done_o or regs_wen_o; busy_o 0. A new MUL 3×4 started at T+12 gives 12 at T+45.
- **Reset mid-CALC:** rstn=1 in cycle T+5 → next cycle all outputs 0 and state IDLE. The following MULHU 2×3 completes normally with result 0.
